reg_file_sb: RTL and testbench

//  Parametrised multi-read-port register file for the pipelined CPU, with a per-entry

---
 rtl/rf_pkg.sv | 27 ++
 rtl/rf_clr_seq.sv | 73 +++++++
 rtl/reg_file_sb.sv | 105 ++++++++++
 tb/tb_reg_file_sb.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
//   Shared types and constants for the scoreboarded register file.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

   // Entry count for the default 5-bit address width
   localparam int DEPTH = 32;

   // Hardware clear sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   // Number of entries addressed by an aw-bit index
   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rf_clr_seq.sv
// ----------------------------------------------------------------------------
// rf_clr_seq
//   Clear sequencer: walks every entry once, writing zero, then pulses done.
//   Comes out of reset already sweeping so the array never holds stale data.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rf_clr_seq
   import rf_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          sweep_start,
   output logic          sweep_we,
   output logic [AW-1:0] sweep_a
);

   clr_state_e    state;
   clr_state_e    state_nxt;
   logic [AW-1:0] idx;

   // State register; reset lands directly in SWEEP
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= SWEEP;
      else       state <= state_nxt;
   end

   // Sweep index advances once per SWEEP cycle and parks at zero otherwise
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)               idx <= '0;
      else if (state == SWEEP) idx <= idx + AW'(1);
      else                     idx <= '0;
   end

   // Next-state and output decode
   always_comb begin
      state_nxt   = state;
      clr_busy    = 1'b0;
      clr_done    = 1'b0;
      sweep_start = 1'b0;
      sweep_we    = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt   = SWEEP;
               sweep_start = 1'b1;
            end
         end
         SWEEP: begin
            clr_busy = 1'b1;
            sweep_we = 1'b1;
            // Last entry reached when the index is all ones
            if (&idx) state_nxt = DONE;
         end
         DONE: begin
            clr_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sweep_a = idx;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
//   Multi-read-port register file with per-entry pending scoreboard and a
//   hardware clear sequencer. Optional same-cycle write-to-read forwarding is
//   enabled by defining REGFILE_BYPASS_EN.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module reg_file_sb
   import rf_pkg::*;
#(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int NR_RD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NR_RD*AW-1:0] rf_ra,
   output logic [NR_RD*DW-1:0] rf_rd,
   output logic [NR_RD-1:0]    rf_pend,
   input  logic                rf_we,
   input  logic [AW-1:0]       rf_wa,
   input  logic [DW-1:0]       rf_wd,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_wa,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                clr_done,
   input  logic [AW-1:0]       dbg_reg_ra,
   output logic [DW-1:0]       dbg_reg_rd
);

   localparam int NENT = depth_of(AW);
   localparam bit ZR   = (ZERO_REG != 0);

   logic [DW-1:0]   mem [NENT];
   logic [NENT-1:0] pend;

   logic            sweep_we;
   logic            sweep_start;
   logic [AW-1:0]   sweep_a;
   logic            we_ok;
   logic            set_ok;

   rf_clr_seq #(
      .AW (AW)
   ) u_clr_seq (
      .clk         (clk),
      .rstn        (rstn),
      .clr_req     (clr_req),
      .clr_busy    (clr_busy),
      .clr_done    (clr_done),
      .sweep_start (sweep_start),
      .sweep_we    (sweep_we),
      .sweep_a     (sweep_a)
   );

   // External writes and scoreboard sets are locked out while sweeping
   assign we_ok  = rf_we  && !clr_busy && !(ZR && (rf_wa == '0));
   assign set_ok = sb_set && !clr_busy && !(ZR && (sb_wa == '0));

   // Array update: sweep zeroing has priority (external write is already gated off)
   always_ff @(posedge clk) begin
      if (sweep_we)   mem[sweep_a] <= '0;
      else if (we_ok) mem[rf_wa]   <= rf_wd;
   end

   // Scoreboard: flushed on sweep, otherwise write clears and issue sets (set last so it wins)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend <= '0;
      end else if (sweep_start || clr_busy) begin
         pend <= '0;
      end else begin
         if (we_ok)  pend[rf_wa] <= 1'b0;
         if (set_ok) pend[sb_wa] <= 1'b1;
      end
   end

   // Read ports
   for (genvar k = 0; k < NR_RD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          is_zero;
      logic          byp;

      assign ra      = rf_ra[k*AW +: AW];
      assign is_zero = ZR && (ra == '0);
`ifdef REGFILE_BYPASS_EN
      assign byp     = we_ok && (rf_wa == ra) && (ra != '0);
`else
      assign byp     = 1'b0;
`endif
      assign rf_rd[k*DW +: DW] = is_zero ? '0 : (byp ? rf_wd : mem[ra]);
      assign rf_pend[k]        = is_zero ? 1'b0 :
                                 (byp ? (set_ok && (sb_wa == ra)) : pend[ra]);
   end

   // Debug port never forwards in-flight write data
   assign dbg_reg_rd = (ZR && (dbg_reg_ra == '0)) ? '0 : mem[dbg_reg_ra];

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
//   Self-checking bench for reg_file_sb against a behavioural reference model.
//   Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int N  = 32;

   logic            clk;
   logic            rstn;
   logic [NR*AW-1:0] rf_ra;
   logic [NR*DW-1:0] rf_rd;
   logic [NR-1:0]    rf_pend;
   logic            rf_we;
   logic [AW-1:0]   rf_wa;
   logic [DW-1:0]   rf_wd;
   logic            sb_set;
   logic [AW-1:0]   sb_wa;
   logic            clr_req;
   logic            clr_busy;
   logic            clr_done;
   logic [AW-1:0]   dbg_reg_ra;
   logic [DW-1:0]   dbg_reg_rd;

   int tests;
   int errors;

   // Reference model state
   logic [DW-1:0] m_mem [N];
   bit            m_val [N];
   bit            m_pend[N];
   bit            m_busy;
   bit            m_done;
   int            m_pos;

   reg_file_sb #(
      .DW(DW), .AW(AW), .NR_RD(NR), .ZERO_REG(1)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rf_ra      (rf_ra),
      .rf_rd      (rf_rd),
      .rf_pend    (rf_pend),
      .rf_we      (rf_we),
      .rf_wa      (rf_wa),
      .rf_wd      (rf_wd),
      .sb_set     (sb_set),
      .sb_wa      (sb_wa),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .dbg_reg_ra (dbg_reg_ra),
      .dbg_reg_rd (dbg_reg_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare every DUT output against the model for the current inputs
   task automatic compare_outputs();
      logic [AW-1:0] ra;
      bit            fwd;
      check("clr_busy", {31'd0, clr_busy}, {31'd0, m_busy});
      check("clr_done", {31'd0, clr_done}, {31'd0, m_done});
      for (int k = 0; k < NR; k++) begin
         ra  = rf_ra[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
         fwd = !m_busy && rf_we && (rf_wa == ra) && (ra != 0);
`else
         fwd = 1'b0;
`endif
         if (ra == 0) begin
            check("rd_zero",   rf_rd[k*DW +: DW], 32'd0);
            check("pend_zero", {31'd0, rf_pend[k]}, 32'd0);
         end else if (fwd) begin
            check("rd_bypass",   rf_rd[k*DW +: DW], rf_wd);
            check("pend_bypass", {31'd0, rf_pend[k]},
                  {31'd0, (sb_set && sb_wa == ra)});
         end else begin
            if (m_val[ra]) check("rd", rf_rd[k*DW +: DW], m_mem[ra]);
            check("pend", {31'd0, rf_pend[k]}, {31'd0, m_pend[ra]});
         end
      end
      if (dbg_reg_ra == 0)       check("dbg_zero", dbg_reg_rd, 32'd0);
      else if (m_val[dbg_reg_ra]) check("dbg", dbg_reg_rd, m_mem[dbg_reg_ra]);
   endtask

   // Advance the model by one clock using the inputs held across the edge
   task automatic model_update();
      if (m_busy) begin
         m_mem[m_pos] = '0;
         m_val[m_pos] = 1'b1;
         if (m_pos == N - 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end else begin
            m_pos++;
         end
      end else begin
         if (rf_we && rf_wa != 0) begin
            m_mem[rf_wa]  = rf_wd;
            m_val[rf_wa]  = 1'b1;
            m_pend[rf_wa] = 1'b0;
         end
         if (sb_set && sb_wa != 0) m_pend[sb_wa] = 1'b1;
         if (!m_done && clr_req) begin
            m_busy = 1'b1;
            m_pos  = 0;
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
         end
         m_done = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      rf_we = 0; sb_set = 0; clr_req = 0;
      rf_wa = 0; rf_wd = 0; sb_wa = 0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_busy = 1'b1;
      m_done = 1'b0;
      m_pos  = 0;
      repeat (2) begin
         @(negedge clk);
         compare_outputs();
         @(posedge clk);
         #1;
      end
      rstn = 1'b1;
   endtask

   // Count sweep cycles after a reset release; the bound guards against a stuck FSM
   task automatic count_sweep(input string tag);
      int n;
      n = 0;
      while (clr_busy && n < 200) begin
         step();
         n++;
      end
      check(tag, n, 32'd32);
      check("done_after_sweep", {31'd0, clr_done}, 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((clr_busy || clr_done) && n < 200) begin
         step();
         n++;
      end
      check("sweep_timeout", {31'd0, clr_busy}, 32'd0);
   endtask

   task automatic set_ra(input int a0, input int a1);
      rf_ra = {AW'(a1), AW'(a0)};
   endtask

   initial begin
      tests  = 0;
      errors = 0;
      rstn   = 1'b0;
      idle_inputs();
      rf_ra      = '0;
      dbg_reg_ra = '0;
      for (int i = 0; i < N; i++) begin
         m_val[i]  = 1'b0;
         m_pend[i] = 1'b0;
         m_mem[i]  = '0;
      end
      @(posedge clk);
      #1;

      // Reset then initial sweep
      do_reset();
      count_sweep("initial_sweep_len");
      step();
      for (int a = 0; a < N; a++) begin
         set_ra(a, N - 1 - a);
         dbg_reg_ra = AW'(a);
         step();
      end

      // Plain write, read back, zero register
      rf_we = 1; rf_wa = 5; rf_wd = 32'hDEADBEEF; set_ra(5, 5);
      step();
      idle_inputs();
      step();
      check("rd_deadbeef", rf_rd[31:0], 32'hDEADBEEF);
      rf_we = 1; rf_wa = 0; rf_wd = 32'hFFFF_FFFF; set_ra(0, 5);
      step();
      idle_inputs();
      step();

      // Scoreboard set, clear by write, same-cycle set+write
      sb_set = 1; sb_wa = 7; set_ra(7, 7);
      step();
      idle_inputs();
      step();
      check("pend_set_7", {31'd0, rf_pend[1]}, 32'd1);
      rf_we = 1; rf_wa = 7; rf_wd = 32'h0000_0777;
      step();
      idle_inputs();
      step();
      check("pend_clr_7", {31'd0, rf_pend[1]}, 32'd0);
      rf_we = 1; rf_wa = 7; rf_wd = 32'h0000_0778; sb_set = 1; sb_wa = 7;
      step();
      idle_inputs();
      step();
      check("pend_set_wins", {31'd0, rf_pend[1]}, 32'd1);

      // Same-cycle write and read of one entry
      rf_we = 1; rf_wa = 3; rf_wd = 32'h11111111; set_ra(3, 0);
      step();
      rf_we = 1; rf_wa = 3; rf_wd = 32'h12345678;
      step();
      idle_inputs();
      step();
      check("rd_after_write3", rf_rd[31:0], 32'h12345678);

      // Clear request; writes during sweep ignored
      rf_we = 1; rf_wa = 9; rf_wd = 32'h000000FF; set_ra(9, 9); dbg_reg_ra = 9;
      step();
      idle_inputs();
      clr_req = 1;
      step();
      clr_req = 0;
      rf_we = 1; rf_wa = 9; rf_wd = 32'hAAAA5555;
      sb_set = 1; sb_wa = 9;
      repeat (5) step();
      idle_inputs();
      wait_idle();
      step();
      check("reg9_cleared", dbg_reg_rd, 32'd0);

      // Reset mid-sweep restarts the full sweep
      sb_set = 1; sb_wa = 12; rf_we = 1; rf_wa = 12; rf_wd = 32'h5A5A5A5A;
      step();
      idle_inputs();
      clr_req = 1;
      step();
      clr_req = 0;
      repeat (10) step();
      do_reset();
      count_sweep("restart_sweep_len");
      step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rf_we   = $urandom_range(0, 1);
         rf_wa   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         rf_wd   = $urandom;
         sb_set  = $urandom_range(0, 1);
         sb_wa   = ($urandom_range(0, 2) == 0) ? rf_wa : AW'($urandom_range(0, 7));
         clr_req = ($urandom_range(0, 149) == 0);
         set_ra(($urandom_range(0, 1) != 0) ? int'(rf_wa) : $urandom_range(0, 31),
                ($urandom_range(0, 1) != 0) ? int'(sb_wa) : $urandom_range(0, 7));
         dbg_reg_ra = AW'($urandom);
         step();
      end
      idle_inputs();
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

`default_nettype wire
